adc_sequencer: RTL and testbench
================================

# adc_sequencer

Sequences the single shared 12-bit ADC between the two player sensors and paces the game. On each game tick it converts player 1 then player 2 through a start/done handshake. It then publishes both results atomically on `p1data`/`p2data` together with a one-cycle `game_tick` strobe. The `single` and `multi` modules consume these, so the race FSM advances once per tick instead of once per clock.

## Interface
Parameters:
- `TICK_DIV`, 1000000: clocks per game tick; legal range 16..2^24.
- `TIMEOUT`, 1023: maximum clocks spent waiting for `adc_done` per conversion.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request; low = stop after the current pair.
- `adc_ready`  in  1  ADC idle and able to accept a start.
- `adc_start`  out  1  one-cycle conversion request.
- `adc_chan`  out  1  channel select (0 = player 1, 1 = player 2); valid while `adc_start` is high and held through the conversion.
- `adc_done`  in  1  one-cycle conversion-complete strobe.
- `adc_data`  in  12  conversion result, valid when `adc_done` is high.
- `p1data`  out  12  published player 1 reading.
- `p2data`  out  12  published player 2 reading.
- `game_tick`  out  1  one-cycle strobe; a fresh pair is valid on `p1data`/`p2data`.
- `overrun`  out  1  sticky; a tick arrived while one was already pending.
- `timeout_err`  out  1  sticky; a conversion exceeded `TIMEOUT`.

## Operation
- States:
  - IDLE: `enable` low.
  - WAIT: waiting for a tick.
  - REQ1, CONV1: player 1 conversion.
  - REQ2, CONV2: player 2 conversion.
  - PUB: publish.
- Tick counter:
  - Counts 0..`TICK_DIV`-1 while `enable` is high, then wraps.
  - Cleared and held at 0 while `enable` is low.
  - The wrap cycle sets `tick_pend`.
  - If `tick_pend` is already set on a wrap, set `overrun` instead. The extra tick is dropped; there is no queueing beyond one deep.
- IDLE -> WAIT when `enable` is high.
- WAIT -> REQ1 when `tick_pend` and `adc_ready` are both high. `tick_pend` clears on that same edge.
- WAIT -> IDLE when `enable` is low.
- REQ1: `adc_start`=1, `adc_chan`=0 for exactly one cycle, then -> CONV1.
- CONV1: on `adc_done`, capture `adc_data` into shadow register `s1`, then -> REQ2.
- REQ2/CONV2: same as REQ1/CONV1 with `adc_chan`=1. On `adc_done`, load `p1data`<=`s1` and `p2data`<=`adc_data` on the same edge, then -> PUB.
- PUB: `game_tick`=1 for one cycle, then -> WAIT. If `enable` is low, go to IDLE instead.
- `adc_done` is ignored in every state except CONV1/CONV2.
- Watchdog:
  - Counts clocks in CONV1/CONV2 and restarts on entry to each.
  - Reaching `TIMEOUT` without `adc_done` sets `timeout_err` and abandons the pair: no publish, previous outputs held, -> WAIT.
- `enable` falling mid-pair: the pair completes and publishes, then the block goes to IDLE.
- `adc_done` arriving on the same cycle the watchdog expires: done wins, no error.
- Sticky flags clear only on reset.
- Reset (asynchronous, any state):
  - State -> IDLE.
  - All outputs, counters, `s1` and `tick_pend` -> 0.
  - An in-flight conversion is abandoned.

## Timing
- Tick wrap at cycle T with `adc_ready` high; WAIT is entered while `tick_pend` is set at T+1.
  - REQ1 at T+2.
  - CONV1 from T+3.
- Zero-wait ADC (done in the first CONV cycle): REQ1 T+2, CONV1 T+3, REQ2 T+4, CONV2 T+5, PUB T+6.
- `game_tick` is high during T+6, with the new data already valid that cycle.
- Each extra ADC wait cycle adds one cycle per conversion.
- `p1data`/`p2data` change only on the edge entering PUB. They are never updated one at a time.
- All outputs are registered, except `adc_start`/`adc_chan`, which are decoded directly from the state register.

## Configuration
- `ADC_AVG_EN` defined:
  - Each channel is converted twice back-to-back (REQ/CONV repeated).
  - The result is (a+b)>>1, using a 13-bit sum and truncating.
  - The watchdog applies to each conversion separately.
  - Zero-wait latency from wrap to PUB becomes T+10.
- `ADC_AVG_EN` undefined: single conversion per channel, as described above.

## Test plan
- `TICK_DIV`=16, zero-wait ADC returning 0x3A0 (chan 0) and 0x1F4 (chan 1) -> `game_tick` 6 cycles after wrap with `p1data`=0x3A0, `p2data`=0x1F4; repeats every 16 cycles.
- ADC holds `adc_ready` low for 20 cycles across two wraps -> `overrun`=1, exactly one pair published once `adc_ready` rises.
- `TIMEOUT`=8 and `adc_done` withheld on chan 1 -> `timeout_err`=1 at the 8th CONV2 cycle, no `game_tick`, outputs unchanged, next tick converts normally.
- `enable` dropped during CONV1 -> pair completes, one `game_tick`, state IDLE, no further `adc_start`.
- `reset` asserted during CONV2 -> all outputs 0 immediately (asynchronously); a late `adc_done` is ignored.
- With `ADC_AVG_EN`, chan 0 samples 0x100 and 0x103 -> `p1data`=0x101.

Source files
------------

// File: rtl/adc_sequencer.sv
`timescale 1ns/1ps
// Purpose: shares one 12-bit ADC between two player sensors and publishes both readings atomically once per game tick.
// Latency: tick wrap at T -> game_tick at T+6 with a zero-wait ADC (T+10 when ADC_AVG_EN averages two samples per channel).
// Backpressure: waits for adc_ready before starting a pair; one tick is held pending, further ticks raise sticky overrun.
module adc_sequencer #(
  parameter int TICK_DIV = 1000000,
  parameter int TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        adc_ready,
  output logic        adc_start,
  output logic        adc_chan,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic [11:0] p1data,
  output logic [11:0] p2data,
  output logic        game_tick,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WAIT, REQ1, CONV1, REQ2, CONV2, PUB} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick_pend;
  logic [WD_W-1:0]  wd_cnt;
  logic [11:0]      s1;
  logic             wrap;
  logic             take;
  logic             in_conv;
  logic             conv_ok;
  logic             wd_exp;
  logic             last_pass;
  logic [11:0]      sample;

  assign wrap    = enable && (tick_cnt == CNT_LAST);
  assign take    = (state == WAIT) && enable && tick_pend && adc_ready;
  assign in_conv = (state == CONV1) || (state == CONV2);
  assign conv_ok = in_conv && adc_done;
  // A done strobe on the expiry cycle takes priority over the watchdog.
  assign wd_exp  = in_conv && !adc_done && (wd_cnt == WD_LAST);

`ifdef ADC_AVG_EN
  logic        second;
  logic [11:0] first_smp;
  logic [12:0] sum;

  assign sum       = {1'b0, first_smp} + {1'b0, adc_data};
  assign sample    = sum[12:1];
  assign last_pass = second;

  // Track which of the two back-to-back samples is in flight and hold the first one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      second    <= 1'b0;
      first_smp <= '0;
    end else if (conv_ok) begin
      second    <= !second;
      first_smp <= adc_data;
    end else if (wd_exp) begin
      second    <= 1'b0;
    end
  end
`else
  assign sample    = adc_data;
  assign last_pass = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; the ADC handshake is decoded straight from the state.
  always_comb begin
    state_nxt = state;
    adc_start = 1'b0;
    adc_chan  = 1'b0;
    case (state)
      IDLE:  if (enable) state_nxt = WAIT;
      WAIT: begin
        if (!enable)                      state_nxt = IDLE;
        else if (tick_pend && adc_ready)  state_nxt = REQ1;
      end
      REQ1: begin
        adc_start = 1'b1;
        state_nxt = CONV1;
      end
      CONV1: begin
        if (adc_done)    state_nxt = last_pass ? REQ2 : REQ1;
        else if (wd_exp) state_nxt = WAIT;
      end
      REQ2: begin
        adc_start = 1'b1;
        adc_chan  = 1'b1;
        state_nxt = CONV2;
      end
      CONV2: begin
        adc_chan = 1'b1;
        if (adc_done)    state_nxt = last_pass ? PUB : REQ2;
        else if (wd_exp) state_nxt = WAIT;
      end
      PUB:     state_nxt = enable ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Tick divider with a one-deep pending tick; a second tick while pending is dropped and flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt  <= '0;
      tick_pend <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (!enable || wrap) tick_cnt <= '0;
      else                 tick_cnt <= tick_cnt + CNT_W'(1);
      if (wrap) begin
        if (tick_pend && !take) overrun <= 1'b1;
        tick_pend <= 1'b1;
      end else if (take) begin
        tick_pend <= 1'b0;
      end
    end
  end

  // Conversion watchdog; restarts on every CONV entry because a REQ cycle always precedes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt <= in_conv ? wd_cnt + WD_W'(1) : '0;
      if (wd_exp) timeout_err <= 1'b1;
    end
  end

  // Shadow player 1 and publish both players on the same edge that enters PUB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1        <= '0;
      p1data    <= '0;
      p2data    <= '0;
      game_tick <= 1'b0;
    end else begin
      if (conv_ok && last_pass && (state == CONV1)) s1 <= sample;
      if (conv_ok && last_pass && (state == CONV2)) begin
        p1data <= s1;
        p2data <= sample;
      end
      game_tick <= (state_nxt == PUB);
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
`timescale 1ns/1ps
// Bench for adc_sequencer: behavioural ADC responder, scoreboard of expected published pairs.
// Expected tick cycles are derived from the wrap schedule of a 16-clock tick.
// Covers reset state, table-driven pairs, overrun, watchdog, enable drop and async reset.
module tb_adc_sequencer;

`ifdef ADC_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        enable;
  logic        adc_ready;
  logic        adc_start;
  logic        adc_chan;
  logic        adc_done;
  logic [11:0] adc_data;
  logic [11:0] p1data;
  logic [11:0] p2data;
  logic        game_tick;
  logic        overrun;
  logic        timeout_err;

  adc_sequencer #(.TICK_DIV(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .adc_ready(adc_ready),
    .adc_start(adc_start), .adc_chan(adc_chan), .adc_done(adc_done),
    .adc_data(adc_data), .p1data(p1data), .p2data(p2data),
    .game_tick(game_tick), .overrun(overrun), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ADC model configuration (written by the main sequence)
  int          m_wait;
  bit          m_block1;
  logic [11:0] m_d0a, m_d0b, m_d1a, m_d1b;

  // Behavioural ADC: done arrives m_wait cycles after the first CONV cycle.
  initial begin
    int cd;
    bit mchan, tog0, tog1;
    cd = 0; mchan = 0; tog0 = 0; tog1 = 0;
    adc_done = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge clk);
      if (adc_start) begin
        cd    = m_wait + 1;
        mchan = adc_chan;
      end
      @(posedge clk);
      #1;
      adc_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !(m_block1 && mchan)) begin
          adc_done = 1'b1;
          if (!mchan) begin
            adc_data = (AVG && tog0) ? m_d0b : m_d0a;
            tog0 = !tog0;
          end else begin
            adc_data = (AVG && tog1) ? m_d1b : m_d1a;
            tog1 = !tog1;
          end
        end
      end
    end
  end

  typedef struct {
    logic [11:0] p1;
    logic [11:0] p2;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [11:0] d0a, d0b, d1a, d1b;
    int          w;
    logic [11:0] e1, e2;
  } vec_t;

  exp_t        sb[$];
  int          n_cmp, n_fail;
  int          cyc, ticks, starts;
  logic [11:0] last_p1, last_p2;

  function automatic logic [11:0] avg12(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[12:1];
  endfunction

  function automatic logic [11:0] pick(input logic [11:0] a, input logic [11:0] b);
    return AVG ? avg12(a, b) : a;
  endfunction

  function automatic int lat(input int w);
    return AVG ? (10 + 4 * w) : (6 + 2 * w);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: sample on the falling edge and score any published pair.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (adc_start) starts++;
    if (game_tick) begin
      ticks++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_tick: got tick with p1=0x%0h p2=0x%0h, expected none (cycle %0d)", p1data, p2data, cyc);
      end else begin
        e = sb.pop_front();
        chk("p1data", int'(p1data), int'(e.p1));
        chk("p2data", int'(p2data), int'(e.p2));
        if (e.cyc >= 0) chk("tick_cycle", cyc, e.cyc);
        last_p1 = e.p1;
        last_p2 = e.p2;
      end
    end
  endtask

  task automatic wait_tick(input string nm, input int bound);
    int t0;
    t0 = ticks;
    for (int i = 0; i < bound && ticks == t0; i++) step();
    chk(nm, ticks - t0, 1);
  endtask

  task automatic set_adc(input logic [11:0] a0, input logic [11:0] b0,
                         input logic [11:0] a1, input logic [11:0] b1, input int w);
    m_d0a = a0; m_d0b = b0; m_d1a = a1; m_d1b = b1; m_wait = w;
  endtask

  task automatic push(input logic [11:0] p1, input logic [11:0] p2, input int c);
    exp_t e;
    e.p1 = p1; e.p2 = p2; e.cyc = c;
    sb.push_back(e);
  endtask

  // Drop enable briefly, then re-enable; returns the cycle on which enable is first seen.
  task automatic restart(output int e_cyc);
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    e_cyc  = cyc;
  endtask

  initial begin
    vec_t vt[5];
    int   e_cyc, w0, t, errc, s0, t0;
    bit   found;

    n_cmp = 0; n_fail = 0; cyc = 0; ticks = 0; starts = 0;
    last_p1 = '0; last_p2 = '0;
    reset = 1'b0; enable = 1'b0; adc_ready = 1'b1; m_block1 = 1'b0;
    set_adc(12'h0, 12'h0, 12'h0, 12'h0, 0);

    vt[0] = '{12'h3A0, 12'h3A0, 12'h1F4, 12'h1F4, 0, 12'h0, 12'h0};
    vt[1] = '{12'h100, 12'h103, 12'hFFF, 12'hFFE, 1, 12'h0, 12'h0};
    vt[2] = '{12'h000, 12'h001, 12'h800, 12'h7FF, 0, 12'h0, 12'h0};
    vt[3] = '{12'hABC, 12'hABF, 12'h555, 12'hAAA, 1, 12'h0, 12'h0};
    vt[4] = '{12'hFFF, 12'hFFF, 12'h001, 12'h000, 0, 12'h0, 12'h0};
    for (int i = 0; i < 5; i++) begin
      vt[i].e1 = pick(vt[i].d0a, vt[i].d0b);
      vt[i].e2 = pick(vt[i].d1a, vt[i].d1b);
    end

    // Reset state
    repeat (3) step();
    chk("rst_p1data", int'(p1data), 0);
    chk("rst_p2data", int'(p2data), 0);
    chk("rst_game_tick", int'(game_tick), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    chk("rst_adc_start", int'(adc_start), 0);
    reset = 1'b1;
    step();

    // Table-driven pairs on consecutive ticks
    restart(e_cyc);
    for (int k = 0; k < 5; k++) begin
      set_adc(vt[k].d0a, vt[k].d0b, vt[k].d1a, vt[k].d1b, vt[k].w);
      push(vt[k].e1, vt[k].e2, e_cyc + 15 + 16 * k + lat(vt[k].w));
      wait_tick($sformatf("vec%0d_tick", k), 40);
    end

    // Overrun: adc_ready low across two wraps, one pair afterwards
    w0 = e_cyc + 15 + 16 * 5;
    while (cyc < w0 - 2) step();
    adc_ready = 1'b0;
    set_adc(12'h246, 12'h246, 12'h468, 12'h468, 0);
    repeat (12) step();
    chk("overrun_one_wrap", int'(overrun), 0);
    repeat (8) step();
    chk("overrun_two_wraps", int'(overrun), 1);
    push(12'h246, 12'h468, cyc + 1 + lat(0) - 2);
    adc_ready = 1'b1;
    t0 = ticks;
    while (cyc < w0 + 31) step();
    chk("overrun_pairs", ticks - t0, 1);

    // Watchdog on chan 1, then a clean pair on the next tick
    restart(e_cyc);
    t = e_cyc + 15;
    m_block1 = 1'b1;
    set_adc(12'h111, 12'h111, 12'h222, 12'h222, 0);
    errc = t + (AVG ? 15 : 13);
    while (cyc < errc - 1) step();
    chk("timeout_before", int'(timeout_err), 0);
    step();
    chk("timeout_set", int'(timeout_err), 1);
    m_block1 = 1'b0;
    chk("timeout_p1_held", int'(p1data), int'(last_p1));
    chk("timeout_p2_held", int'(p2data), int'(last_p2));
    push(12'h111, 12'h222, t + 16 + lat(0));
    wait_tick("after_timeout_tick", 40);

    // Enable dropped during CONV1: pair completes, then no more starts
    restart(e_cyc);
    t = e_cyc + 15;
    set_adc(12'h5A5, 12'h5A5, 12'h6B6, 12'h6B6, 2);
    while (cyc < t + 3) step();
    chk("en_drop_in_conv1", int'(adc_start || !(!adc_chan)), 0);
    enable = 1'b0;
    push(12'h5A5, 12'h6B6, t + lat(2));
    wait_tick("en_drop_tick", 40);
    s0 = starts;
    repeat (40) step();
    chk("en_drop_no_start", starts - s0, 0);

    // Asynchronous reset during CONV2 with a late done
    restart(e_cyc);
    set_adc(12'h777, 12'h777, 12'h333, 12'h333, 3);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step();
      if (adc_chan && !adc_start) found = 1'b1;
    end
    chk("reached_conv2", int'(found), 1);
    reset = 1'b0;
    #1;
    chk("arst_p1data", int'(p1data), 0);
    chk("arst_p2data", int'(p2data), 0);
    chk("arst_overrun", int'(overrun), 0);
    chk("arst_timeout_err", int'(timeout_err), 0);
    chk("arst_adc_start", int'(adc_start), 0);
    chk("arst_adc_chan", int'(adc_chan), 0);
    step();
    reset = 1'b1;
    repeat (12) step();
    chk("late_done_p1", int'(p1data), 0);
    chk("late_done_p2", int'(p2data), 0);
    chk("late_done_timeout", int'(timeout_err), 0);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
